// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (640x480@60), sync-polarity type and decode helpers
// used by the timing generator and its delay line.
package vga_pkg;

  localparam int unsigned H_DISP_DEF  = 640;
  localparam int unsigned H_FP_DEF    = 16;
  localparam int unsigned H_SYNC_DEF  = 96;
  localparam int unsigned H_BP_DEF    = 48;
  localparam int unsigned V_DISP_DEF  = 480;
  localparam int unsigned V_FP_DEF    = 10;
  localparam int unsigned V_SYNC_DEF  = 2;
  localparam int unsigned V_BP_DEF    = 33;
  localparam int unsigned H_TOTAL_DEF = H_DISP_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL_DEF = V_DISP_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  typedef enum logic {
    POL_LOW  = 1'b0,
    POL_HIGH = 1'b1
  } sync_pol_e;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
  } vga_sig_t;

  // Pin level of a sync signal given whether it is asserted.
  function automatic logic sync_level(input logic active, input sync_pol_e pol);
    return active ? logic'(pol) : ~logic'(pol);
  endfunction

  function automatic logic in_window(input int unsigned pos, input int unsigned lo,
                                     input int unsigned len);
    return (pos >= lo) && (pos < lo + len);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Timing-generator port bundle: run enable in; pixel tick, counters, sync,
// blanking and strobes out.
interface vga_timing_gen_if #(
  parameter int unsigned CW = 10
);
  logic          en;
  logic          p_tick;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          hsync;
  logic          vsync;
  logic          video_on;
  logic          line_start;
  logic          frame_start;
  logic          hsync_d;
  logic          vsync_d;
  logic          video_on_d;

  modport master (
    output en,
    input  p_tick, x, y, hsync, vsync, video_on, line_start, frame_start,
           hsync_d, vsync_d, video_on_d
  );

  modport slave (
    input  en,
    output p_tick, x, y, hsync, vsync, video_on, line_start, frame_start,
           hsync_d, vsync_d, video_on_d
  );
endinterface

// File: rtl/vga_sig_delay.sv
// Tick-enabled shift register: dout lags din by DEPTH shift pulses; DEPTH=0 is a
// combinational pass-through.
module vga_sig_delay #(
  parameter int unsigned          WIDTH     = 3,
  parameter int unsigned          DEPTH     = 0,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_ok;
    assign unused_ok = ^{clk, reset, shift};
    assign dout      = din;
  end else begin : g_chain
    logic [DEPTH-1:0][WIDTH-1:0] stage_q;
    logic [DEPTH-1:0][WIDTH-1:0] stage_d;

    assign stage_d[0] = shift ? din : stage_q[0];
    for (genvar i = 1; i < DEPTH; i++) begin : g_stage
      assign stage_d[i] = shift ? stage_q[i-1] : stage_q[i];
    end

    always_ff @(posedge clk) begin
      if (reset) stage_q <= {DEPTH{RESET_VAL}};
      else       stage_q <= stage_d;
    end

    assign dout = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised video timing generator: pixel-tick divider, h/v counters, sync and
// blanking decode, line/frame strobes and a tick-aligned delayed sync/blank bundle.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_DISP  = H_DISP_DEF,
  parameter int unsigned H_FP    = H_FP_DEF,
  parameter int unsigned H_SYNC  = H_SYNC_DEF,
  parameter int unsigned H_BP    = H_BP_DEF,
  parameter int unsigned V_DISP  = V_DISP_DEF,
  parameter int unsigned V_FP    = V_FP_DEF,
  parameter int unsigned V_SYNC  = V_SYNC_DEF,
  parameter int unsigned V_BP    = V_BP_DEF,
  parameter sync_pol_e   H_POL   = POL_LOW,
  parameter sync_pol_e   V_POL   = POL_LOW,
  parameter int unsigned PIX_DIV = 4,
  parameter int unsigned DELAY   = 0,
  parameter int unsigned CW      = 10
) (
  input logic             clk,
  input logic             reset,
  vga_timing_gen_if.slave vif
);

  localparam int unsigned   H_TOTAL  = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int unsigned   V_TOTAL  = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int unsigned   PW       = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [PW-1:0] PIX_LAST = PW'(PIX_DIV - 1);
  localparam logic [CW-1:0] X_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] Y_LAST   = CW'(V_TOTAL - 1);
  localparam vga_sig_t      SIG_RST  = '{hsync:    sync_level(1'b0, H_POL),
                                         vsync:    sync_level(1'b0, V_POL),
                                         video_on: 1'b1};
  // Delay stages start blanked so downstream sees no video before the pipe fills.
  localparam vga_sig_t      DLY_RST  = '{hsync:    sync_level(1'b0, H_POL),
                                         vsync:    sync_level(1'b0, V_POL),
                                         video_on: 1'b0};

  logic [PW-1:0] pix_cnt_q, pix_cnt_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic [CW-1:0] x_nxt, y_nxt;
  vga_sig_t      sig_q, sig_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic          p_tick_c;
  vga_sig_t      dly_out;

  assign p_tick_c = (pix_cnt_q == PIX_LAST) && vif.en && !reset;

  // Next-count decode: sync/blank are loaded together with x/y so they never skew.
  always_comb begin
    pix_cnt_d     = pix_cnt_q;
    x_d           = x_q;
    y_d           = y_q;
    sig_d         = sig_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    x_nxt = (x_q == X_LAST) ? '0 : x_q + CW'(1);
    y_nxt = y_q;
    if (x_q == X_LAST) y_nxt = (y_q == Y_LAST) ? '0 : y_q + CW'(1);

    if (vif.en) pix_cnt_d = (pix_cnt_q == PIX_LAST) ? '0 : pix_cnt_q + PW'(1);

    if (p_tick_c) begin
      x_d            = x_nxt;
      y_d            = y_nxt;
      sig_d.hsync    = sync_level(in_window(32'(x_nxt), H_DISP + H_FP, H_SYNC), H_POL);
      sig_d.vsync    = sync_level(in_window(32'(y_nxt), V_DISP + V_FP, V_SYNC), V_POL);
      sig_d.video_on = (32'(x_nxt) < H_DISP) && (32'(y_nxt) < V_DISP);
      line_start_d   = (x_nxt == '0);
      frame_start_d  = (x_nxt == '0) && (y_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_cnt_q     <= '0;
      x_q           <= '0;
      y_q           <= '0;
      sig_q         <= SIG_RST;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      pix_cnt_q     <= pix_cnt_d;
      x_q           <= x_d;
      y_q           <= y_d;
      sig_q         <= sig_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  vga_sig_delay #(
    .WIDTH     ($bits(vga_sig_t)),
    .DEPTH     (DELAY),
    .RESET_VAL (DLY_RST)
  ) u_sig_delay (
    .clk   (clk),
    .reset (reset),
    .shift (p_tick_c),
    .din   (sig_q),
    .dout  (dly_out)
  );

  assign vif.p_tick      = p_tick_c;
  assign vif.x           = x_q;
  assign vif.y           = y_q;
  assign vif.hsync       = sig_q.hsync;
  assign vif.vsync       = sig_q.vsync;
  assign vif.video_on    = sig_q.video_on;
  assign vif.line_start  = line_start_q;
  assign vif.frame_start = frame_start_q;
  assign vif.hsync_d     = dly_out.hsync;
  assign vif.vsync_d     = dly_out.vsync;
  assign vif.video_on_d  = dly_out.video_on;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations (default, tiny timing, DELAY=2)
// checked against a closed-form timing model through an expected-value queue.
module tb_vga_timing_gen;
  import vga_pkg::*;

  typedef struct packed {
    int unsigned hd, hf, hs, hb, vd, vf, vs, vb, d;
    logic        hp, vp;
  } tim_t;

  typedef struct packed {
    logic       pt;
    logic [9:0] x, y;
    logic       hs, vs, vo, ls, fs;
  } obs_t;

  typedef struct packed {
    logic hs, vs, vo;
  } dly_t;

  localparam tim_t T_DEF = '{hd: H_DISP_DEF, hf: H_FP_DEF, hs: H_SYNC_DEF, hb: H_BP_DEF,
                             vd: V_DISP_DEF, vf: V_FP_DEF, vs: V_SYNC_DEF, vb: V_BP_DEF,
                             d: 4, hp: 1'b0, vp: 1'b0};
  localparam tim_t T_TINY = '{hd: 4, hf: 1, hs: 2, hb: 1, vd: 3, vf: 1, vs: 1, vb: 1,
                              d: 1, hp: 1'b1, vp: 1'b1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_def  = 1'b1;
  logic rst_tiny = 1'b1;
  logic rst_dly  = 1'b1;

  int   n_checks = 0;
  int   n_pass   = 0;
  obs_t exp_q[$];
  dly_t dexp_q[$];

  vga_timing_gen_if #(.CW(10)) if_def ();
  vga_timing_gen_if #(.CW(10)) if_tiny ();
  vga_timing_gen_if #(.CW(10)) if_dly ();

  vga_timing_gen #(.PIX_DIV(4), .DELAY(0), .CW(10)) u_def (
    .clk(clk), .reset(rst_def), .vif(if_def));

  vga_timing_gen #(.H_DISP(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                   .V_DISP(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
                   .H_POL(POL_HIGH), .V_POL(POL_HIGH),
                   .PIX_DIV(1), .DELAY(0), .CW(10)) u_tiny (
    .clk(clk), .reset(rst_tiny), .vif(if_tiny));

  vga_timing_gen #(.PIX_DIV(4), .DELAY(2), .CW(10)) u_dly (
    .clk(clk), .reset(rst_dly), .vif(if_dly));

  // Expected outputs k clks after the last reset edge, with en held high throughout.
  function automatic obs_t model(input tim_t t, input int unsigned k);
    obs_t        o;
    int unsigned ht, vt, n, xi, yi;
    ht   = t.hd + t.hf + t.hs + t.hb;
    vt   = t.vd + t.vf + t.vs + t.vb;
    n    = k / t.d;
    xi   = n % ht;
    yi   = (n / ht) % vt;
    o.pt = ((k % t.d) == t.d - 1);
    o.x  = 10'(xi);
    o.y  = 10'(yi);
    o.hs = (xi >= t.hd + t.hf && xi < t.hd + t.hf + t.hs) ? t.hp : ~t.hp;
    o.vs = (yi >= t.vd + t.vf && yi < t.vd + t.vf + t.vs) ? t.vp : ~t.vp;
    o.vo = (xi < t.hd) && (yi < t.vd);
    o.ls = (k > 0) && ((k % t.d) == 0) && (xi == 0);
    o.fs = o.ls && (yi == 0);
    return o;
  endfunction

  function automatic dly_t dmodel(input tim_t t, input int unsigned k, input int unsigned depth);
    dly_t r;
    obs_t o;
    if (k / t.d < depth) begin
      r.hs = ~t.hp;
      r.vs = ~t.vp;
      r.vo = 1'b0;
    end else begin
      o    = model(t, k - depth * t.d);
      r.hs = o.hs;
      r.vs = o.vs;
      r.vo = o.vo;
    end
    return r;
  endfunction

  function automatic obs_t get_obs(input int which);
    obs_t o;
    case (which)
      0:       o = {if_def.p_tick, if_def.x, if_def.y, if_def.hsync, if_def.vsync,
                    if_def.video_on, if_def.line_start, if_def.frame_start};
      1:       o = {if_tiny.p_tick, if_tiny.x, if_tiny.y, if_tiny.hsync, if_tiny.vsync,
                    if_tiny.video_on, if_tiny.line_start, if_tiny.frame_start};
      default: o = {if_dly.p_tick, if_dly.x, if_dly.y, if_dly.hsync, if_dly.vsync,
                    if_dly.video_on, if_dly.line_start, if_dly.frame_start};
    endcase
    return o;
  endfunction

  function automatic dly_t get_d(input int which);
    dly_t r;
    case (which)
      0:       r = {if_def.hsync_d, if_def.vsync_d, if_def.video_on_d};
      1:       r = {if_tiny.hsync_d, if_tiny.vsync_d, if_tiny.video_on_d};
      default: r = {if_dly.hsync_d, if_dly.vsync_d, if_dly.video_on_d};
    endcase
    return r;
  endfunction

  // Two reset edges; returns #1 after the last one with reset already released (k=0).
  task automatic reset_dut(input int which);
    case (which)
      0:       rst_def  = 1'b1;
      1:       rst_tiny = 1'b1;
      default: rst_dly  = 1'b1;
    endcase
    repeat (2) @(posedge clk);
    #1;
    case (which)
      0:       rst_def  = 1'b0;
      1:       rst_tiny = 1'b0;
      default: rst_dly  = 1'b0;
    endcase
  endtask

  task automatic test_reset();
    obs_t o, e, r;
    reset_dut(0);
    for (int unsigned k = 1; k <= 1201; k++) begin
      exp_q.push_back(model(T_DEF, k));
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = get_obs(0);
      n_checks++;
      if (o !== e) $display("FAIL reset_run k=%0d got=%h exp=%h", k, o, e);
      else n_pass++;
    end
    r    = model(T_DEF, 0);
    r.pt = 1'b0;
    rst_def = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(r);
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = get_obs(0);
      n_checks++;
      if (o !== e) $display("FAIL reset_hold cyc=%0d got=%h exp=%h", i, o, e);
      else n_pass++;
    end
    rst_def = 1'b0;
    for (int unsigned k = 0; k <= 5; k++) begin
      exp_q.push_back(model(T_DEF, k));
      if (k > 0) begin @(posedge clk); #1; end
      e = exp_q.pop_front(); o = get_obs(0);
      n_checks++;
      if (o !== e) $display("FAIL reset_release k=%0d got=%h exp=%h", k, o, e);
      else n_pass++;
    end
  endtask

  task automatic test_line_timing();
    obs_t        o, e;
    dly_t        dd, de;
    int unsigned ls_k[$];
    int unsigned hs_low = 0;
    reset_dut(0);
    for (int unsigned k = 1; k <= 6500; k++) begin
      exp_q.push_back(model(T_DEF, k));
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = get_obs(0);
      n_checks++;
      if (o !== e) $display("FAIL line_state k=%0d got=%h exp=%h", k, o, e);
      else n_pass++;
      de = {e.hs, e.vs, e.vo};
      dd = get_d(0);
      n_checks++;
      if (dd !== de) $display("FAIL line_passthru k=%0d got=%h exp=%h", k, dd, de);
      else n_pass++;
      if (o.ls) ls_k.push_back(k);
      if (ls_k.size() == 1 && !o.hs) hs_low++;
    end
    n_checks++;
    if (ls_k.size() < 2) $display("FAIL line_period got=%0d strobes exp=2", ls_k.size());
    else if (ls_k[1] - ls_k[0] != H_TOTAL_DEF * 4)
      $display("FAIL line_period got=%0d exp=%0d", ls_k[1] - ls_k[0], H_TOTAL_DEF * 4);
    else n_pass++;
    n_checks++;
    if (hs_low != H_SYNC_DEF * 4) $display("FAIL hsync_width got=%0d exp=%0d", hs_low, H_SYNC_DEF * 4);
    else n_pass++;
  endtask

  task automatic test_tiny_frame();
    obs_t        o, e;
    dly_t        dd, de;
    int unsigned fs_k[$];
    reset_dut(1);
    for (int unsigned k = 1; k <= 100; k++) begin
      exp_q.push_back(model(T_TINY, k));
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = get_obs(1);
      n_checks++;
      if (o !== e) $display("FAIL tiny_state k=%0d got=%h exp=%h", k, o, e);
      else n_pass++;
      de = {e.hs, e.vs, e.vo};
      dd = get_d(1);
      n_checks++;
      if (dd !== de) $display("FAIL tiny_passthru k=%0d got=%h exp=%h", k, dd, de);
      else n_pass++;
      if (o.fs) fs_k.push_back(k);
    end
    n_checks++;
    if (fs_k.size() < 2) $display("FAIL frame_period got=%0d strobes exp=2", fs_k.size());
    else if (fs_k[1] - fs_k[0] != 48) $display("FAIL frame_period got=%0d exp=48", fs_k[1] - fs_k[0]);
    else n_pass++;
  endtask

  task automatic test_wrap();
    obs_t o, e;
    bit   found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      o = get_obs(1);
      if (o.x == 10'd7 && o.y == 10'd5) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    n_checks++;
    if (!found) $display("FAIL wrap_reach got=not_reached exp=x7_y5");
    else n_pass++;
    exp_q.push_back('{pt: 1'b1, x: 10'd0, y: 10'd0, hs: 1'b0, vs: 1'b0, vo: 1'b1, ls: 1'b1, fs: 1'b1});
    exp_q.push_back('{pt: 1'b1, x: 10'd1, y: 10'd0, hs: 1'b0, vs: 1'b0, vo: 1'b1, ls: 1'b0, fs: 1'b0});
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = get_obs(1);
      n_checks++;
      if (o !== e) $display("FAIL wrap_strobes cyc=%0d got=%h exp=%h", i, o, e);
      else n_pass++;
    end
  endtask

  task automatic test_delay();
    obs_t        o;
    dly_t        dd, de;
    logic        hs_prev, hsd_prev;
    int unsigned hs_fall = 0, hsd_fall = 0;
    reset_dut(2);
    hs_prev  = get_obs(2).hs;
    hsd_prev = get_d(2).hs;
    for (int unsigned k = 0; k <= 6500; k++) begin
      dexp_q.push_back(dmodel(T_DEF, k, 2));
      if (k > 0) begin @(posedge clk); #1; end
      de = dexp_q.pop_front(); dd = get_d(2); o = get_obs(2);
      n_checks++;
      if (dd !== de) $display("FAIL delay_out k=%0d got=%h exp=%h", k, dd, de);
      else n_pass++;
      if (hs_prev && !o.hs && hs_fall == 0) hs_fall = k;
      if (hsd_prev && !dd.hs && hsd_fall == 0) hsd_fall = k;
      hs_prev  = o.hs;
      hsd_prev = dd.hs;
    end
    n_checks++;
    if (hs_fall == 0 || hsd_fall != hs_fall + 8)
      $display("FAIL delay_lag got=%0d exp=8 (hsync fall at %0d)", hsd_fall - hs_fall, hs_fall);
    else n_pass++;
  endtask

  task automatic test_enable();
    obs_t o, e, held;
    reset_dut(0);
    for (int unsigned k = 1; k <= 401; k++) begin
      exp_q.push_back(model(T_DEF, k));
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = get_obs(0);
      n_checks++;
      if (o !== e) $display("FAIL en_run k=%0d got=%h exp=%h", k, o, e);
      else n_pass++;
    end
    held    = model(T_DEF, 401);
    held.pt = 1'b0;
    if_def.en = 1'b0;
    for (int i = 0; i < 50; i++) begin
      exp_q.push_back(held);
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = get_obs(0);
      n_checks++;
      if (o !== e) $display("FAIL en_hold cyc=%0d got=%h exp=%h", i, o, e);
      else n_pass++;
    end
    if_def.en = 1'b1;
    for (int unsigned k = 402; k <= 420; k++) begin
      exp_q.push_back(model(T_DEF, k));
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = get_obs(0);
      n_checks++;
      if (o !== e) $display("FAIL en_resume k=%0d got=%h exp=%h", k, o, e);
      else n_pass++;
    end
    reset_dut(1);
    for (int unsigned k = 1; k <= 8; k++) begin
      exp_q.push_back(model(T_TINY, k));
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = get_obs(1);
      n_checks++;
      if (o !== e) $display("FAIL en_tiny_run k=%0d got=%h exp=%h", k, o, e);
      else n_pass++;
    end
    held    = model(T_TINY, 8);
    held.pt = 1'b0;
    held.ls = 1'b0;
    if_tiny.en = 1'b0;
    exp_q.push_back(held);
    @(posedge clk); #1;
    e = exp_q.pop_front(); o = get_obs(1);
    n_checks++;
    if (o !== e) $display("FAIL en_strobe_drop got=%h exp=%h", o, e);
    else n_pass++;
    if_tiny.en = 1'b1;
  endtask

  initial begin
    if_def.en  = 1'b1;
    if_tiny.en = 1'b1;
    if_dly.en  = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_line_timing();
    test_tiny_frame();
    test_wrap();
    test_delay();
    test_enable();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised video timing generator, successor to the fixed 640x480 sync unit. It divides the system clock into a pixel tick and runs horizontal/vertical counters over fully parametrised timings. It outputs sync with selectable polarity, `video_on`, and line/frame start strobes. A programmable pixel-tick delay line realigns sync and blanking with the registered RGB path of the downstream renderer (heart sprite, play area, HP bars).

## Interface
- `H_DISP`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (ticks)
- `H_SYNC`, 96, hsync width (ticks)
- `H_BP`, 48, horizontal back porch (ticks)
- `V_DISP`, 480, visible lines
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `H_POL`, 0, hsync active level (0 = active-low)
- `V_POL`, 0, vsync active level (0 = active-low)
- `PIX_DIV`, 4, clk cycles per pixel tick, 1..16
- `DELAY`, 0, pixel-tick delay of the `_d` outputs, 0..15
- `CW`, 10, counter width; requires H_TOTAL, V_TOTAL ≤ 2^CW
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `en`  in  1  run enable; low freezes all state
- `p_tick`  out  1  pixel tick, one clk wide
- `x`  out  CW  horizontal count
- `y`  out  CW  vertical count
- `hsync`, `vsync`  out  1  sync, aligned with `x`/`y`
- `video_on`  out  1  high when x < H_DISP and y < V_DISP
- `line_start`  out  1  one-clk pulse, first clk of x = 0
- `frame_start`  out  1  one-clk pulse, first clk of x = 0, y = 0
- `hsync_d`, `vsync_d`, `video_on_d`  out  1  sync and video_on delayed by DELAY ticks

## Operation
- Timing constants: H_TOTAL = H_DISP+H_FP+H_SYNC+H_BP; hsync active for H_DISP+H_FP ≤ x < H_DISP+H_FP+H_SYNC. Vertical is analogous.
- Divider: `pix_cnt` runs 0..PIX_DIV-1 while `en`=1. `p_tick` = (pix_cnt == PIX_DIV-1) && en && !reset. With PIX_DIV=1, `p_tick` = en && !reset.
- On `p_tick`: x wraps H_TOTAL-1 → 0, otherwise increments. y advances only when x wraps, and wraps V_TOTAL-1 → 0.
- `hsync`, `vsync` and `video_on` are registered from the next-count decode on the same `p_tick`, so they never skew from `x`/`y`.
- Output level of a sync = active ? POL : ~POL.
- `line_start`/`frame_start` are registered. They are high for exactly one clk after the `p_tick` that loads x=0 (and y=0 for `frame_start`). Otherwise they are low.
- Delay line: DELAY-stage shift register of {hsync, vsync, video_on}, shifted on `p_tick`. With DELAY=0 the `_d` outputs equal the undelayed ones combinationally.
- `en`=0 holds the divider, counters, sync, delay line and all registered outputs. Strobes drop to 0 after one clk. On re-enable, operation resumes from the held `pix_cnt`.
- Reset dominates `en` and applies mid-frame with no partial-frame completion.
- Reset values:
  - `pix_cnt`, `x`, `y` = 0
  - `hsync` = ~H_POL, `vsync` = ~V_POL
  - `video_on` = 1 (decode of (0,0))
  - `line_start`, `frame_start` = 0
  - every delay stage = {~H_POL, ~V_POL, 0}, so `_d` outputs are inactive until DELAY ticks elapse.

## Timing
- Single clock domain, all state updates on posedge `clk`.
- First `p_tick` occurs PIX_DIV-1 clks after `reset` falls, given `en`=1.
- Line period = H_TOTAL·PIX_DIV clks; frame period = H_TOTAL·V_TOTAL·PIX_DIV clks.
- `_d` outputs lag undelayed outputs by exactly DELAY·PIX_DIV clks.
- No combinational path from `en` to `x`/`y`/sync. The only `en`/`reset` paths are to `p_tick` and to `_d` when DELAY=0.

## Structure
- Shared package `vga_pkg`: 640x480@60 default timing constants, the derived H_TOTAL/V_TOTAL, and a sync-polarity enum.
- Sub-module `vga_sig_delay` (parameters WIDTH, DEPTH, RESET_VAL; input `shift`): generic tick-enabled shift register. It is instantiated once for the 3-bit {hsync, vsync, video_on} bundle.

## Test plan
- **Reset:** hold `reset` 3 clks mid-line at x=300 → next clk x=0, y=0, hsync=vsync=1, video_on=1, strobes 0; first `p_tick` 3 clks after release.
- **Default timing, PIX_DIV=4:** hsync low exactly for x=656..751 (384 clks); `line_start` every 3200 clks; vsync low for y=490..491; `frame_start` every 1,680,000 clks.
- **Tiny timing (H 4/1/2/1, V 3/1/1/1, PIX_DIV=1, H_POL=V_POL=1):**
  - x cycles 0..7 and y cycles 0..5.
  - hsync high at x=5..6; video_on high only for x<4 and y<3.
  - `frame_start` every 48 clks.
- **DELAY=2, PIX_DIV=4:** `hsync_d` falls 8 clks after `hsync`; `video_on_d`=0 for the first 8 clks after reset.
- **Enable:** drop `en` at x=100 for 50 clks → x, y, pix_cnt and sync unchanged, no `p_tick`. On re-enable, x=101 arrives after the remaining divider count.
- **Wrap and simultaneous strobes:** at x=H_TOTAL-1, y=V_TOTAL-1, the next `p_tick` gives x=y=0 and `line_start` and `frame_start` high in the same single clk.
